// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_scanner_pkg;

    localparam int VEC_COUNT = 8;  // input vectors per scan (3 inputs)
    localparam int IDX_W     = 3;  // width of the vector index
    localparam int CNT_W     = 4;  // mismatch counter / settle timer width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // A vector mismatches when either observed output differs from its expectation.
    function automatic logic vec_mismatch(input logic s1_obs, input logic s2_obs,
                                          input logic s1_exp, input logic s2_exp);
        return (s1_obs != s1_exp) || (s2_obs != s2_exp);
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: 4-bit down-counter that flags the last cycle of a settle window.
// Latency: expire_o is high in the SETTLE-th cycle after the load phase ends.
// Backpressure: none; the counter only runs while en_i is high.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load_i    - reload the counter (held high whenever the scanner is not settling)
//   en_i      - count down (high while the scanner is settling)
//   expire_o  - settle window ends this cycle
module truth_table_scanner_settle_timer
    import truth_table_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    // Reloading with SETTLE-1 makes the count hit zero in the SETTLE-th enabled cycle.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks {x,y,z} through 0..7, samples s1/s2 and checks them against expected tables.
// Latency: done pulses 8*(SETTLE+1)+1 cycles after the start edge.
// Backpressure: none; start is ignored while a scan (or its done cycle) is in progress.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset (overrides everything)
//   start               - one-cycle scan request, honoured only in IDLE
//   x, y, z             - stimulus to the function under test, {x,y,z} = vector index
//   s1, s2              - responses of the function under test
//   busy                - high while settling or capturing
//   done                - one-cycle pulse at scan end
//   pass                - last completed scan had no mismatches
//   err_count           - number of mismatching vectors (0..8)
//   first_err_idx       - lowest mismatching vector index (0 when none)
//   s1_tbl, s2_tbl      - captured responses, bit i = sample at index i
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int                   SETTLE = 1,
    parameter logic [VEC_COUNT-1:0] EXP_S1 = 8'h0C,
    parameter logic [VEC_COUNT-1:0] EXP_S2 = 8'h0C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 x,
    output logic                 y,
    output logic                 z,
    input  logic                 s1,
    input  logic                 s2,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [IDX_W-1:0]     first_err_idx,
    output logic [VEC_COUNT-1:0] s1_tbl,
    output logic [VEC_COUNT-1:0] s2_tbl
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     xyz_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CNT_W-1:0]     err_q;
    logic [IDX_W-1:0]     first_q;
    logic [VEC_COUNT-1:0] s1_tbl_q;
    logic [VEC_COUNT-1:0] s2_tbl_q;

    logic                 settle_expired;
    logic                 cap_mism;
    logic [CNT_W-1:0]     err_d;

    // Timer reloads in every non-settling state so each SETTLE phase starts fresh.
    truth_table_scanner_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q != ST_SETTLE),
        .en_i     (state_q == ST_SETTLE),
        .expire_o (settle_expired)
    );

    // Mismatch of the vector being captured; a vector counts once even if both outputs differ.
    always_comb begin
        cap_mism = vec_mismatch(s1, s2, EXP_S1[idx_q], EXP_S2[idx_q]);
        err_d    = err_q;
        if ((state_q == ST_CAPTURE) && cap_mism) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            xyz_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            s1_tbl_q <= '0;
            s2_tbl_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // Results are held here until the next accepted start clears them.
                    if (start) begin
                        state_q  <= ST_SETTLE;
                        idx_q    <= '0;
                        xyz_q    <= '0;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        err_q    <= '0;
                        first_q  <= '0;
                        s1_tbl_q <= '0;
                        s2_tbl_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_expired) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    s1_tbl_q[idx_q] <= s1;
                    s2_tbl_q[idx_q] <= s2;
                    err_q           <= err_d;
                    if (cap_mism && (err_q == '0)) begin
                        first_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        // idx is left at the last vector; IDLE restarts it from 0.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        xyz_q   <= '0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= ST_SETTLE;
                        idx_q   <= idx_q + 1'b1;
                        xyz_q   <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x             = xyz_q[2];
    assign y             = xyz_q[1];
    assign z             = xyz_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign s1_tbl        = s1_tbl_q;
    assign s2_tbl        = s2_tbl_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench: two scanners (SETTLE=1 default tables, SETTLE=3 with 0D/08 tables) each probing a registered
// function whose truth tables are chosen per scan; expected scan results are queued at start and
// checked, together with the per-cycle busy/done/{x,y,z} timeline, by a negedge monitor.
module tb_truth_table_scanner;

    typedef struct {
        int         sc;     // cycle in which start was driven
        int         err;
        int         first;
        int         pass;
        logic [7:0] t1;
        logic [7:0] t2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] x, y, z, busy, done, pass;
    logic [1:0] s1 = 2'b00;
    logic [1:0] s2 = 2'b00;
    logic [3:0] err   [2];
    logic [2:0] first [2];
    logic [7:0] t1    [2];
    logic [7:0] t2    [2];
    logic [7:0] f1    [2];
    logic [7:0] f2    [2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sbq  [2][$];
    exp_t last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        truth_table_scanner #(
            .SETTLE (g == 0 ? 1 : 3),
            .EXP_S1 (g == 0 ? 8'h0C : 8'h0D),
            .EXP_S2 (g == 0 ? 8'h0C : 8'h08)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start[g]),
            .x             (x[g]),
            .y             (y[g]),
            .z             (z[g]),
            .s1            (s1[g]),
            .s2            (s2[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .pass          (pass[g]),
            .err_count     (err[g]),
            .first_err_idx (first[g]),
            .s1_tbl        (t1[g]),
            .s2_tbl        (t2[g])
        );
    end

    // Function under test: table lookup with one register stage of latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            s1[i] <= f1[i][{x[i], y[i], z[i]}];
            s2[i] <= f2[i][{x[i], y[i], z[i]}];
        end
    end

    function automatic int settle_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction
    function automatic logic [7:0] e1_of(input int g);
        return (g == 0) ? 8'h0C : 8'h0D;
    endfunction
    function automatic logic [7:0] e2_of(input int g);
        return (g == 0) ? 8'h0C : 8'h08;
    endfunction

    task automatic chk(input int g, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", g, name, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int g);
        int   s, len, k;
        bit   act;
        exp_t e;
        s   = settle_of(g);
        len = 8 * (s + 1);
        act = (sbq[g].size() > 0) && (cyc > sbq[g][0].sc);
        if (act) begin
            k = cyc - sbq[g][0].sc;
            chk(g, "busy", int'(busy[g]), (k <= len) ? 1 : 0);
            chk(g, "done", int'(done[g]), (k == len + 1) ? 1 : 0);
            chk(g, "xyz", int'({x[g], y[g], z[g]}), (k <= len) ? (k - 1) / (s + 1) : 0);
            if (k == 1) begin
                chk(g, "clr_err", int'(err[g]), 0);
                chk(g, "clr_first", int'(first[g]), 0);
                chk(g, "clr_pass", int'(pass[g]), 0);
                chk(g, "clr_s1_tbl", int'(t1[g]), 0);
                chk(g, "clr_s2_tbl", int'(t2[g]), 0);
            end
            if (k == len + 1) begin
                e = sbq[g].pop_front();
                chk(g, "err_count", int'(err[g]), e.err);
                chk(g, "first_err_idx", int'(first[g]), e.first);
                chk(g, "pass", int'(pass[g]), e.pass);
                chk(g, "s1_tbl", int'(t1[g]), int'(e.t1));
                chk(g, "s2_tbl", int'(t2[g]), int'(e.t2));
                last[g] = e;
            end
        end else begin
            chk(g, "idle_busy", int'(busy[g]), 0);
            chk(g, "idle_done", int'(done[g]), 0);
            chk(g, "idle_xyz", int'({x[g], y[g], z[g]}), 0);
            chk(g, "hold_err", int'(err[g]), last[g].err);
            chk(g, "hold_first", int'(first[g]), last[g].first);
            chk(g, "hold_pass", int'(pass[g]), last[g].pass);
            chk(g, "hold_s1_tbl", int'(t1[g]), int'(last[g].t1));
            chk(g, "hold_s2_tbl", int'(t2[g]), int'(last[g].t2));
        end
        // Reset sampled at the coming edge abandons any scan and zeroes all results.
        if (rst) begin
            sbq[g].delete();
            last[g] = '{default: 0};
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            monitor(0);
            monitor(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the function tables, queue the expected scan outcome and raise start.
    task automatic issue(input int g, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] m;
        f1[g] = a;
        f2[g] = b;
        m       = (a ^ e1_of(g)) | (b ^ e2_of(g));
        e.sc    = cyc;
        e.err   = $countones(m);
        e.first = 0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) e.first = i;
        end
        e.pass = (m == 8'h00) ? 1 : 0;
        e.t1   = a;
        e.t2   = b;
        sbq[g].push_back(e);
        start[g] = 1'b1;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (sbq[g].size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (sbq[g].size() > 0) begin
            errors++;
            $display("FAIL dut%0d scan_timeout: scan still pending after %0d cycles", g, n);
            sbq[g].delete();
        end
    endtask

    function automatic logic [7:0] rand_tbl(input logic [7:0] ref_tbl);
        logic [7:0] r;
        r = 8'($urandom);
        case ($urandom_range(0, 2))
            0:       return ref_tbl;
            1:       return ref_tbl ^ (8'h01 << $urandom_range(0, 7));
            default: return r;
        endcase
    endfunction

    task automatic random_scans(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            issue(g, rand_tbl(e1_of(g)), rand_tbl(e2_of(g)));
            tick();
            start[g] = 1'b0;
            wait_idle(g);
            // Sometimes restart in the cycle right after done, sometimes idle a while.
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        f1[0] = 8'h00; f1[1] = 8'h00;
        f2[0] = 8'h00; f2[1] = 8'h00;
        last[0] = '{default: 0};
        last[1] = '{default: 0};
        rst = 1'b1;
        repeat (3) tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // s1 = s2 = ~x & y on both scanners.
        issue(0, 8'h0C, 8'h0C);
        issue(1, 8'h0C, 8'h0C);
        tick();
        start = 2'b00;
        wait_idle(0);
        wait_idle(1);
        repeat (2) tick();

        // Start re-pulsed in cycle 5 of a scan must be ignored.
        issue(0, 8'h0C, 8'h0C);
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_idle(0);

        // Reset in cycle 9 of a scan, then a full fresh scan.
        issue(0, 8'($urandom), 8'($urandom));
        issue(1, 8'($urandom), 8'($urandom));
        tick();
        start = 2'b00;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        issue(0, 8'h0C, 8'h0C);
        tick();
        start[0] = 1'b0;
        wait_idle(0);

        // Randomized traffic, back-to-back and gapped, on both scanners at once.
        fork
            random_scans(0, 8);
            random_scans(1, 5);
        join
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE, default 1, meaning: cycles each input vector is held before the outputs are sampled; legal range 1..15.
REQ-002 Parameter EXP_S1, default 8'h0C, meaning: expected s1 truth table, bit i is the expected value for input index i.
REQ-003 Parameter EXP_S2, default 8'h0C, meaning: expected s2 truth table, bit i is the expected value for input index i.
REQ-004 clk  input  1  meaning: single clock; all state updates on the rising edge.
REQ-005 rst  input  1  meaning: synchronous, active-high reset.
REQ-006 start  input  1  meaning: one-cycle scan request.
REQ-007 x, y, z  output  1 each  meaning: drive to the function under test; index i = {x,y,z}, x is the MSB.
REQ-008 s1, s2  input  1 each  meaning: outputs of the function under test.
REQ-009 busy  output  1  meaning: scan in progress.
REQ-010 done  output  1  meaning: one-cycle pulse at scan end.
REQ-011 pass  output  1  meaning: last completed scan had zero mismatches.
REQ-012 err_count  output  4  meaning: number of indices with an s1 or s2 mismatch, 0..8.
REQ-013 first_err_idx  output  3  meaning: lowest mismatching index; 0 when there is none.
REQ-014 s1_tbl, s2_tbl  output  8 each  meaning: captured truth tables, bit i = sample at index i.

Function
REQ-015 FSM states IDLE, SETTLE, CAPTURE, DONE; busy SHALL be high exactly in SETTLE and CAPTURE.
REQ-016 IDLE with start=1 SHALL move to SETTLE with idx=0, and SHALL clear err_count, first_err_idx, s1_tbl, s2_tbl and pass.
REQ-017 {x,y,z} SHALL equal idx while busy, and SHALL be 3'b000 in IDLE and DONE.
REQ-018 SETTLE SHALL last exactly SETTLE cycles, then go to CAPTURE.
REQ-019 CAPTURE (one cycle) SHALL write s1 to s1_tbl[idx] and s2 to s2_tbl[idx], and compare them against EXP_S1[idx] and EXP_S2[idx].
REQ-020 On a mismatch at idx, err_count SHALL increment by 1 (counted once even if both outputs mismatch); first_err_idx SHALL load idx only if err_count was 0.
REQ-021 CAPTURE with idx<7 SHALL increment idx and return to SETTLE; with idx==7 it SHALL go to DONE, with no wrap of idx.
REQ-022 DONE SHALL last one cycle, with done=1 and pass=(err_count==0) registered; it SHALL then go to IDLE.
REQ-023 Timing: start sampled at edge 0; vector i occupies cycles 1+i*(SETTLE+1) .. (i+1)*(SETTLE+1); done SHALL be high in cycle 8*(SETTLE+1)+1.
REQ-024 start SHALL be ignored in SETTLE, CAPTURE and DONE.
REQ-025 start in the cycle after DONE SHALL begin a new scan normally.
REQ-026 pass, err_count, first_err_idx and the tables SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst=1 SHALL force the IDLE state, idx=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, s1_tbl=0, s2_tbl=0 and {x,y,z}=0 at the next edge.
REQ-028 rst SHALL take priority over start and over every state transition, including in the middle of a scan.

Structure
REQ-029 A shared package SHALL hold: the state enum, VEC_COUNT=8, IDX_W=3, and CNT_W=4.
REQ-030 A settle_timer sub-module SHALL contain the 4-bit down-counter that generates the SETTLE expiry pulse; everything else stays in truth_table_scanner.

Verification
REQ-031 DUT s1=s2=~x&y, defaults, start -> done in cycle 17, pass=1, err_count=0, s1_tbl=s2_tbl=8'h0C.
REQ-032 Same DUT, EXP_S1=8'h0D, EXP_S2=8'h08 -> err_count=2, first_err_idx=0, pass=0.
REQ-033 SETTLE=3, start -> done in cycle 33, and {x,y,z} steps 000..111, each value held for 4 cycles.
REQ-034 start re-pulsed in cycle 5 of a scan -> no restart, and done still in cycle 17.
REQ-035 rst in cycle 9 (idx=4) -> next cycle IDLE with all outputs 0; a new start then gives a full, correct scan.
REQ-036 Back-to-back: start in the cycle after done -> counts and tables cleared, then the second scan's results are reported.
